// File: rtl/debug_readout_sequencer_if.sv
// Word stream between the debug readout sequencer (master) and the hex text renderer (slave).
interface debug_readout_sequencer_if;
  logic        outWordValid;
  logic        inWordReady;
  logic [63:0] outWordData;
  logic [2:0]  outWordIndex;
  logic        outWordLast;

  modport master (
    output outWordValid,
    input  inWordReady,
    output outWordData,
    output outWordIndex,
    output outWordLast
  );

  modport slave (
    input  outWordValid,
    output inWordReady,
    input  outWordData,
    input  outWordIndex,
    input  outWordLast
  );
endinterface

// File: rtl/debug_readout_sequencer.sv
// Snapshots one debug source per frame tick and streams status + four debug words to the overlay.
// Optional feature macro: DEBUG_AUTOCYCLE_EN (automatic source advance every AUTOCYCLE_FRAMES ticks).
module debug_readout_sequencer #(
  parameter int NUM_SYSTEMS      = 4,
  parameter int AUTOCYCLE_FRAMES = 60
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inJoypadUp_tick,
  input  logic                      inJoypadDown_tick,
  input  logic                      inJoypadSelect_tick,
  input  logic                      inFrameStart_tick,
  input  logic [7:0]                statusInfo,
  input  logic [64*NUM_SYSTEMS-1:0] inDebugA,
  input  logic [64*NUM_SYSTEMS-1:0] inDebugB,
  input  logic [64*NUM_SYSTEMS-1:0] inDebugC,
  input  logic [64*NUM_SYSTEMS-1:0] inDebugD,
  debug_readout_sequencer_if.master word_if,
  output logic [3:0]                outSelectedSystem,
  output logic                      outFrozen,
  output logic [7:0]                outOverrunCount
);

  if (NUM_SYSTEMS < 2 || NUM_SYSTEMS > 16) begin : g_bad_num_systems
    $error("debug_readout_sequencer: NUM_SYSTEMS must be 2..16");
  end
  if (AUTOCYCLE_FRAMES < 2 || AUTOCYCLE_FRAMES > 255) begin : g_bad_autocycle
    $error("debug_readout_sequencer: AUTOCYCLE_FRAMES must be 2..255");
  end

  localparam logic [3:0] SEL_MAX = 4'(NUM_SYSTEMS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [3:0]  sel_reg, sel_next;
  logic        frozen_reg, frozen_next;
  logic [7:0]  overrun_reg, overrun_next;
  logic        load;
  logic        word_valid;

  logic [63:0] buf_reg  [0:4];
  logic [63:0] cap_word [0:4];

  // Sources padded to 16 so the 4-bit selection indexes them without width games.
  logic [63:0] dbg_a [0:15];
  logic [63:0] dbg_b [0:15];
  logic [63:0] dbg_c [0:15];
  logic [63:0] dbg_d [0:15];

  for (genvar gi = 0; gi < 16; gi++) begin : g_src
    if (gi < NUM_SYSTEMS) begin : g_live
      assign dbg_a[gi] = inDebugA[64*gi +: 64];
      assign dbg_b[gi] = inDebugB[64*gi +: 64];
      assign dbg_c[gi] = inDebugC[64*gi +: 64];
      assign dbg_d[gi] = inDebugD[64*gi +: 64];
    end else begin : g_pad
      assign dbg_a[gi] = 64'h0;
      assign dbg_b[gi] = 64'h0;
      assign dbg_c[gi] = 64'h0;
      assign dbg_d[gi] = 64'h0;
    end
  end

  // Capture uses the registered selection, so a same-edge joypad change lands after the snapshot.
  assign cap_word[0] = {4'h0, sel_reg, 48'h0, statusInfo};
  assign cap_word[1] = dbg_a[sel_reg];
  assign cap_word[2] = dbg_b[sel_reg];
  assign cap_word[3] = dbg_c[sel_reg];
  assign cap_word[4] = dbg_d[sel_reg];

  for (genvar gi = 0; gi < 5; gi++) begin : g_buf
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        buf_reg[gi] <= 64'h0;
      end else if (load) begin
        buf_reg[gi] <= cap_word[gi];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    overrun_next = overrun_reg;
    load         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (inFrameStart_tick) begin
          load       = !frozen_reg;
          state_next = STREAM;
          idx_next   = 3'd0;
        end
      end
      STREAM: begin
        if (inFrameStart_tick && overrun_reg != 8'hFF) begin
          overrun_next = overrun_reg + 8'd1;
        end
        if (word_if.inWordReady) begin
          if (idx_reg == 3'd4) begin
            state_next = IDLE;
            idx_next   = 3'd0;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= 3'd0;
      overrun_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      overrun_reg <= overrun_next;
    end
  end

`ifdef DEBUG_AUTOCYCLE_EN
  localparam logic [7:0] AUTO_LAST = 8'(AUTOCYCLE_FRAMES - 1);
  logic [7:0] cnt_reg, cnt_next;
`endif

  always_comb begin
    sel_next    = sel_reg;
    frozen_next = frozen_reg ^ inJoypadSelect_tick;
    if (inJoypadUp_tick && !frozen_reg) begin
      if (sel_reg != SEL_MAX) begin
        sel_next = sel_reg + 4'd1;
      end
    end else if (inJoypadDown_tick && !frozen_reg) begin
      if (sel_reg != 4'd0) begin
        sel_next = sel_reg - 4'd1;
      end
    end
`ifdef DEBUG_AUTOCYCLE_EN
    cnt_next = cnt_reg;
    // A joypad press restarts the dwell and suppresses the wrap on the same edge.
    if (inJoypadUp_tick || inJoypadDown_tick) begin
      cnt_next = 8'd0;
    end else if (inFrameStart_tick && !frozen_reg) begin
      if (cnt_reg == AUTO_LAST) begin
        cnt_next = 8'd0;
        sel_next = (sel_reg == SEL_MAX) ? 4'd0 : sel_reg + 4'd1;
      end else begin
        cnt_next = cnt_reg + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_reg    <= 4'd0;
      frozen_reg <= 1'b0;
    end else begin
      sel_reg    <= sel_next;
      frozen_reg <= frozen_next;
    end
  end

`ifdef DEBUG_AUTOCYCLE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg <= 8'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`endif

  assign word_valid           = (state_reg == STREAM);
  assign word_if.outWordValid = word_valid;
  assign word_if.outWordData  = word_valid ? buf_reg[idx_reg] : 64'h0;
  assign word_if.outWordIndex = idx_reg;
  assign word_if.outWordLast  = (idx_reg == 3'd4);

  assign outSelectedSystem = sel_reg;
  assign outFrozen         = frozen_reg;
  assign outOverrunCount   = overrun_reg;

endmodule

// File: tb/tb_debug_readout_sequencer.sv
// Directed bench for debug_readout_sequencer: inputs change on the falling edge, outputs are checked there too.
module tb_debug_readout_sequencer;
  localparam int NS = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           up = 1'b0, down = 1'b0, sel_tick = 1'b0, frame = 1'b0;
  logic [7:0]     status = 8'h00;
  logic [64*NS-1:0] dbg_a = '0, dbg_b = '0, dbg_c = '0, dbg_d = '0;
  logic [3:0]     selected;
  logic           frozen;
  logic [7:0]     overrun;

  int total = 0;
  int bad   = 0;

  debug_readout_sequencer_if wif ();

  debug_readout_sequencer #(
    .NUM_SYSTEMS      (NS),
    .AUTOCYCLE_FRAMES (3)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .inJoypadUp_tick     (up),
    .inJoypadDown_tick   (down),
    .inJoypadSelect_tick (sel_tick),
    .inFrameStart_tick   (frame),
    .statusInfo          (status),
    .inDebugA            (dbg_a),
    .inDebugB            (dbg_b),
    .inDebugC            (dbg_c),
    .inDebugD            (dbg_d),
    .word_if             (wif.master),
    .outSelectedSystem   (selected),
    .outFrozen           (frozen),
    .outOverrunCount     (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] gen(int which, int s, logic [7:0] seed);
    case (which)
      1:       return {8'hA0, seed, 40'h0, 8'(s)};
      2:       return {32'hDEADBEEF, seed, 16'h0, 8'(s)};
      3:       return {8'hC0, seed, 40'h0, 8'(s)};
      default: return {8'hD0, seed, 40'h0, 8'(s)};
    endcase
  endfunction

  function automatic logic [63:0] exp_word(int k, int s, logic [7:0] st, logic [7:0] seed);
    if (k == 0) return {8'(s), 48'h0, st};
    return gen(k, s, seed);
  endfunction

  task automatic set_debug(logic [7:0] seed);
    for (int s = 0; s < NS; s++) begin
      dbg_a[64*s +: 64] = gen(1, s, seed);
      dbg_b[64*s +: 64] = gen(2, s, seed);
      dbg_c[64*s +: 64] = gen(3, s, seed);
      dbg_d[64*s +: 64] = gen(4, s, seed);
    end
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_word(string tag, int k, int s, logic [7:0] st, logic [7:0] seed);
    check({tag, " valid"}, 64'(wif.outWordValid), 64'd1);
    check({tag, " index"}, 64'(wif.outWordIndex), 64'(k));
    check({tag, " data"},  wif.outWordData, exp_word(k, s, st, seed));
    check({tag, " last"},  64'(wif.outWordLast), 64'(k == 4));
    $display("word %0d sys=%0d data=%h last=%0b", k, s, wif.outWordData, wif.outWordLast);
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    @(negedge clock);
    frame = 1'b0;
  endtask

  task automatic pulse_select();
    sel_tick = 1'b1;
    @(negedge clock);
    sel_tick = 1'b0;
  endtask

  task automatic stream_full(string tag, int s, logic [7:0] st, logic [7:0] seed);
    for (int k = 0; k < 5; k++) begin
      check_word(tag, k, s, st, seed);
      @(negedge clock);
    end
    check({tag, " valid after last"}, 64'(wif.outWordValid), 64'd0);
  endtask

  initial begin
    int exp_idx;
    int xfers;
    wif.inWordReady = 1'b0;
    set_debug(8'h00);

    #1;
    check("reset valid", 64'(wif.outWordValid), 64'd0);
    check("reset data", wif.outWordData, 64'd0);
    check("reset index", 64'(wif.outWordIndex), 64'd0);
    check("reset last", 64'(wif.outWordLast), 64'd0);
    check("reset sel", 64'(selected), 64'd0);
    check("reset frozen", 64'(frozen), 64'd0);
    check("reset overrun", 64'(overrun), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Basic stream from system 2
    status = 8'h5A;
    up = 1'b1;
    repeat (2) @(negedge clock);
    up = 1'b0;
    check("sel after two up", 64'(selected), 64'd2);
    wif.inWordReady = 1'b1;
    pulse_frame();
    check("word0 literal", wif.outWordData, 64'h0200_0000_0000_005A);
    stream_full("basic", 2, 8'h5A, 8'h00);
    check("word2 literal", gen(2, 2, 8'h00), 64'hDEAD_BEEF_0000_0002);

    // Ready pattern 1,0,0,1,1,...
    status = 8'h33;
    wif.inWordReady = 1'b0;
    pulse_frame();
    exp_idx = 0;
    xfers = 0;
    for (int c = 0; c < 20; c++) begin
      if (!wif.outWordValid) break;
      check("toggle index", 64'(wif.outWordIndex), 64'(exp_idx));
      check("toggle data", wif.outWordData, exp_word(exp_idx, 2, 8'h33, 8'h00));
      $display("cycle %0d index=%0d data=%h", c, wif.outWordIndex, wif.outWordData);
      wif.inWordReady = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      if (wif.inWordReady) begin
        xfers++;
        exp_idx++;
      end
      @(negedge clock);
    end
    check("toggle transfers", 64'(xfers), 64'd5);
    check("toggle valid end", 64'(wif.outWordValid), 64'd0);

    // Overrun saturation
    wif.inWordReady = 1'b0;
    pulse_frame();
    frame = 1'b1;
    repeat (300) @(negedge clock);
    frame = 1'b0;
    check("overrun sat", 64'(overrun), 64'd255);
    $display("overrun count=%0d", overrun);
    wif.inWordReady = 1'b1;
    stream_full("overrun", 2, 8'h33, 8'h00);

    // Freeze keeps the previous buffer and blocks Up
    pulse_select();
    check("frozen on", 64'(frozen), 64'd1);
    set_debug(8'h5E);
    status = 8'h77;
    up = 1'b1;
    @(negedge clock);
    up = 1'b0;
    check("up ignored frozen", 64'(selected), 64'd2);
    pulse_frame();
    stream_full("frozen", 2, 8'h33, 8'h00);
    pulse_select();
    check("frozen off", 64'(frozen), 64'd0);
    pulse_frame();
    stream_full("unfrozen", 2, 8'h77, 8'h5E);

    // Selection edge cases
    down = 1'b1;
    @(negedge clock);
    down = 1'b0;
    check("down to 1", 64'(selected), 64'd1);
    up = 1'b1;
    down = 1'b1;
    @(negedge clock);
    up = 1'b0;
    down = 1'b0;
    check("up wins", 64'(selected), 64'd2);
    up = 1'b1;
    repeat (2) @(negedge clock);
    up = 1'b0;
    check("up saturates", 64'(selected), 64'd3);
    down = 1'b1;
    repeat (4) @(negedge clock);
    down = 1'b0;
    check("down saturates", 64'(selected), 64'd0);

    // Asynchronous reset mid-stream
    up = 1'b1;
    @(negedge clock);
    up = 1'b0;
    pulse_select();
    wif.inWordReady = 1'b0;
    pulse_frame();
    check("pre-reset valid", 64'(wif.outWordValid), 64'd1);
    reset = 1'b1;
    #1;
    check("mid reset valid", 64'(wif.outWordValid), 64'd0);
    check("mid reset data", wif.outWordData, 64'd0);
    check("mid reset index", 64'(wif.outWordIndex), 64'd0);
    check("mid reset sel", 64'(selected), 64'd0);
    check("mid reset frozen", 64'(frozen), 64'd0);
    check("mid reset overrun", 64'(overrun), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Three frame ticks at selection 3
    up = 1'b1;
    repeat (3) @(negedge clock);
    up = 1'b0;
    check("sel 3", 64'(selected), 64'd3);
    wif.inWordReady = 1'b1;
    pulse_frame();
    repeat (6) @(negedge clock);
    check("sel after tick1", 64'(selected), 64'd3);
    pulse_frame();
    repeat (6) @(negedge clock);
    check("sel after tick2", 64'(selected), 64'd3);
    pulse_frame();
    check("tick3 word0", wif.outWordData, exp_word(0, 3, 8'h77, 8'h00));
`ifdef DEBUG_AUTOCYCLE_EN
    check("autocycle wrap", 64'(selected), 64'd0);
`else
    check("no autocycle", 64'(selected), 64'd3);
`endif
    $display("tick3 sel=%0d word0=%h", selected, wif.outWordData);
    repeat (6) @(negedge clock);
    check("tick3 stream done", 64'(wif.outWordValid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
